// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: 2-stage pipelined bus multiplexer with select-error counter; define BUS_MUX_RR_EN for round-robin arbitration
module bus_mux_pipe #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_SRC   = 24,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int ERR_CNT_W = 8
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic [NUM_SRC*WORD_SIZE-1:0] src_data,
  input  logic [NUM_SRC-1:0]           src_out,
  input  logic                         stall,
  output logic [WORD_SIZE-1:0]         bus_out,
  output logic                         bus_valid,
  output logic [SEL_W-1:0]             bus_sel,
  output logic                         sel_err,
  output logic [ERR_CNT_W-1:0]         err_count
`ifdef BUS_MUX_RR_EN
  , output logic [NUM_SRC-1:0]         grant_vec
`endif
);
  logic                 req_valid, req_err;
  logic [SEL_W-1:0]     req_sel;
  logic [WORD_SIZE-1:0] req_data;
  logic                 s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
  logic [SEL_W-1:0]     s1_sel_q, s1_sel_d, bus_sel_q, bus_sel_d;
  logic [WORD_SIZE-1:0] s1_data_q, s1_data_d, bus_out_q, bus_out_d;
  logic                 bus_valid_q, bus_valid_d, sel_err_q, sel_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
`ifdef BUS_MUX_RR_EN
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0]   req_gnt, s1_gnt_q, s1_gnt_d, gnt_q, gnt_d;
  // round-robin grant: first request at or above rr_ptr, wrapping; multi-hot is legal
  always_comb begin
    int idx;
    logic found;
    idx = 0;
    found = 1'b0;
    req_sel = '0;
    req_err = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_SRC;
      if (!found && src_out[idx]) begin
        found = 1'b1;
        req_sel = SEL_W'(idx);
      end
    end
    req_gnt = NUM_SRC'(1) << req_sel;
  end
`else
  // fixed priority: lowest set index wins, any second request flags an error
  always_comb begin
    req_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) if (src_out[i]) req_sel = SEL_W'(i);
    req_err = |(src_out & (src_out - NUM_SRC'(1)));
  end
`endif
  assign req_valid = |src_out;
  assign req_data  = src_data[req_sel*WORD_SIZE +: WORD_SIZE];
  // next state: both stages advance together unless stalled; bus word/select hold across bubbles
  always_comb begin
    s1_valid_d  = stall ? s1_valid_q : req_valid;
    s1_sel_d    = stall ? s1_sel_q   : req_sel;
    s1_data_d   = stall ? s1_data_q  : req_data;
    s1_err_d    = stall ? s1_err_q   : req_err;
    bus_valid_d = stall ? bus_valid_q : s1_valid_q;
    sel_err_d   = stall ? sel_err_q   : s1_err_q;
    bus_out_d   = (!stall && s1_valid_q) ? s1_data_q : bus_out_q;
    bus_sel_d   = (!stall && s1_valid_q) ? s1_sel_q  : bus_sel_q;
    err_count_d = (!stall && s1_err_q && err_count_q != '1) ? err_count_q + ERR_CNT_W'(1) : err_count_q;
`ifdef BUS_MUX_RR_EN
    rr_ptr_d    = (stall || !req_valid) ? rr_ptr_q :
                  (req_sel == SEL_W'(NUM_SRC - 1)) ? '0 : req_sel + SEL_W'(1);
    s1_gnt_d    = stall ? s1_gnt_q : req_gnt;
    gnt_d       = (!stall && s1_valid_q) ? s1_gnt_q : gnt_q;
`endif
  end
  // pipeline registers, cleared asynchronously
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s1_valid_q  <= 1'b0;
      s1_sel_q    <= '0;
      s1_data_q   <= '0;
      s1_err_q    <= 1'b0;
      bus_valid_q <= 1'b0;
      bus_sel_q   <= '0;
      bus_out_q   <= '0;
      sel_err_q   <= 1'b0;
      err_count_q <= '0;
`ifdef BUS_MUX_RR_EN
      rr_ptr_q    <= '0;
      s1_gnt_q    <= '0;
      gnt_q       <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sel_q    <= s1_sel_d;
      s1_data_q   <= s1_data_d;
      s1_err_q    <= s1_err_d;
      bus_valid_q <= bus_valid_d;
      bus_sel_q   <= bus_sel_d;
      bus_out_q   <= bus_out_d;
      sel_err_q   <= sel_err_d;
      err_count_q <= err_count_d;
`ifdef BUS_MUX_RR_EN
      rr_ptr_q    <= rr_ptr_d;
      s1_gnt_q    <= s1_gnt_d;
      gnt_q       <= gnt_d;
`endif
    end
  end
  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign bus_sel   = bus_sel_q;
  assign sel_err   = sel_err_q;
  assign err_count = err_count_q;
`ifdef BUS_MUX_RR_EN
  assign grant_vec = gnt_q;
`endif
endmodule

// File: tb/tb_bus_mux_pipe.sv
// tb_bus_mux_pipe: directed self-checking bench for bus_mux_pipe
module tb_bus_mux_pipe;
  localparam int W = 32;
  localparam int N = 24;
  logic           clock, clear, stall;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_out;
  logic [W-1:0]   bus_out;
  logic           bus_valid, sel_err;
  logic [4:0]     bus_sel;
  logic [7:0]     err_count;
`ifdef BUS_MUX_RR_EN
  logic [N-1:0]   grant_vec;
`endif
  int n_cmp = 0;
  int n_err = 0;

  bus_mux_pipe dut (
    .clock(clock), .clear(clear), .src_data(src_data), .src_out(src_out), .stall(stall),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_sel(bus_sel), .sel_err(sel_err),
    .err_count(err_count)
`ifdef BUS_MUX_RR_EN
    , .grant_vec(grant_vec)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    src_data[i*W +: W] = v;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    #2;
    clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1;
    stall = 1'b0;
    src_out = N'($urandom);
    for (int i = 0; i < N; i++) set_word(i, $urandom);
    tick();
    tick();
    chk("rst_bus_out", bus_out, 0);
    chk("rst_valid", bus_valid, 0);
    chk("rst_sel", bus_sel, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_err_count", err_count, 0);
    clear = 1'b0;
    src_out = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_valid", bus_valid, 0);
      chk("idle_bus_out", bus_out, 0);
    end

    set_word(21, 32'hDEADBEEF);
    src_out = N'(1) << 21;
    tick();
    src_out = '0;
    tick();
    chk("mdr_bus_out", bus_out, 32'hDEADBEEF);
    chk("mdr_sel", bus_sel, 21);
    chk("mdr_valid", bus_valid, 1);
    chk("mdr_sel_err", sel_err, 0);

    for (int i = 0; i < N; i++) set_word(i, 32'h1000 + i);
    for (int i = 0; i < N; i++) begin
      src_out = N'(1) << i;
      tick();
      if (i > 0) begin
        chk("sweep_bus_out", bus_out, 32'h1000 + i - 1);
        chk("sweep_sel", bus_sel, i - 1);
        chk("sweep_valid", bus_valid, 1);
      end
    end
    src_out = '0;
    tick();
    chk("sweep_last_out", bus_out, 32'h1000 + 23);
    chk("sweep_last_sel", bus_sel, 23);

`ifndef BUS_MUX_RR_EN
    do_reset();
    set_word(2, 32'h2);
    set_word(5, 32'h5);
    src_out = 24'h000024;
    tick();
    src_out = '0;
    tick();
    chk("mh_bus_out", bus_out, 32'h2);
    chk("mh_sel", bus_sel, 2);
    chk("mh_sel_err", sel_err, 1);
    chk("mh_err_count", err_count, 1);
    tick();
    chk("mh_pulse_end", sel_err, 0);
    chk("mh_count_hold", err_count, 1);
    src_out = 24'h000024;
    for (int k = 0; k < 300; k++) tick();
    chk("sat_err_count", err_count, 8'hFF);
    src_out = '0;
    tick();
    tick();
    chk("sat_no_wrap", err_count, 8'hFF);
    do_reset();
    src_out = 24'h000024;
    tick();
    stall = 1'b1;
    src_out = '0;
    tick();
    stall = 1'b0;
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("stall_err_once", err_count, 1);
    chk("stall_err_held", sel_err, 1);
    stall = 1'b0;
`endif

    do_reset();
    set_word(3, 32'h1234);
    set_word(7, 32'h7777);
    src_out = N'(1) << 3;
    tick();
    tick();
    chk("st_load", bus_out, 32'h1234);
    stall = 1'b1;
    src_out = N'(1) << 7;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("st_hold_out", bus_out, 32'h1234);
      chk("st_hold_valid", bus_valid, 1);
    end
    stall = 1'b0;
    src_out = '0;
    tick();
    chk("st_resume_out", bus_out, 32'h1234);
    chk("st_resume_sel", bus_sel, 3);
    tick();
    chk("st_bubble_valid", bus_valid, 0);
    chk("st_no_src7", bus_out, 32'h1234);
    chk("st_no_src7_sel", bus_sel, 3);

    set_word(0, 32'hA5A5A5A5);
    src_out = N'(1);
    tick();
    src_out = '0;
    tick();
    chk("bub_out", bus_out, 32'hA5A5A5A5);
    chk("bub_valid", bus_valid, 1);
    chk("bub_sel", bus_sel, 0);
    tick();
    chk("bub_fall", bus_valid, 0);
    chk("bub_hold_out", bus_out, 32'hA5A5A5A5);
    chk("bub_hold_sel", bus_sel, 0);

    src_out = N'(1) << 9;
    tick();
    tick();
    #2;
    clear = 1'b1;
    #1;
    chk("async_out", bus_out, 0);
    chk("async_valid", bus_valid, 0);
    chk("async_sel", bus_sel, 0);
    clear = 1'b0;
    src_out = '0;
    tick();
    tick();
    chk("post_rst_bubble", bus_valid, 0);

`ifdef BUS_MUX_RR_EN
    do_reset();
    src_out = 24'hFFFFFF;
    tick();
    for (int k = 0; k < 26; k++) begin
      tick();
      chk("rr_sel", bus_sel, k % N);
      chk("rr_grant", grant_vec, N'(1) << (k % N));
      chk("rr_sel_err", sel_err, 0);
      chk("rr_err_count", err_count, 0);
    end
    #2;
    clear = 1'b1;
    #2;
    clear = 1'b0;
    tick();
    tick();
    chk("rr_restart", bus_sel, 0);
    tick();
    chk("rr_restart_next", bus_sel, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
